pcs_rx_align_ctrl: RTL and testbench

- Link bring-up and alignment supervisor for the multi-lane PCS receive path.
- Watches per-lane block lock, per-lane alignment-marker (AM) lock and the deskew stage, then sequences deskew restart, lane resync and datapath enable.
- Asserts align_status only when all lanes are locked, deskewed and receiving AMs in the same cycle.
- Sits beside the lane reorder/deskew/descrambler chain and drives its control inputs.

---
 rtl/pcs_rx_pkg.sv | 20 ++
 rtl/pcs_rx_align_err_cnt.sv | 42 ++++
 rtl/pcs_rx_align_ctrl.sv | 152 +++++++++++++++
 tb/tb_pcs_rx_align_ctrl.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/pcs_rx_pkg.sv
// Shared definitions for the PCS receive alignment path.
// Holds the alignment FSM state encoding (also exported on the debug state port)
// and the per-rate lane count and alignment-marker period constants.
package pcs_rx_pkg;

    typedef enum logic [2:0] {
        StWaitBlk = 3'd0,
        StWaitAm  = 3'd1,
        StDeskew  = 3'd2,
        StAligned = 3'd3,
        StLoss    = 3'd4
    } align_state_e;

    localparam int unsigned AM_PERIOD_40G  = 16384;
    localparam int unsigned AM_PERIOD_100G = AM_PERIOD_40G;

    localparam int unsigned LANE_N_40G  = 4;
    localparam int unsigned LANE_N_100G = 20;

endpackage

// File: rtl/pcs_rx_align_err_cnt.sv
// Saturating consecutive-error counter.
// Ports:
//   clk, nreset  - clock and synchronous active-low reset
//   clr_i        - clear the count (wins over inc_i)
//   inc_i        - count one error event
//   cnt_o        - current count
//   hit_o        - combinational: the event on inc_i this cycle brings the count to THRESH
module pcs_rx_align_err_cnt #(
    parameter int unsigned WIDTH  = 2,
    parameter int unsigned THRESH = 3
) (
    input  logic             clk,
    input  logic             nreset,
    input  logic             clr_i,
    input  logic             inc_i,
    output logic [WIDTH-1:0] cnt_o,
    output logic             hit_o
);

    logic [WIDTH-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i && (cnt_q != {WIDTH{1'b1}})) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!nreset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;
    assign hit_o = inc_i && !clr_i && ((32'(cnt_q) + 32'd1) >= THRESH);

endmodule

// File: rtl/pcs_rx_align_ctrl.sv
// PCS receive link bring-up / alignment supervisor.
// Sequences WAIT_BLK -> WAIT_AM -> DESKEW -> ALIGNED, dropping through a one-cycle
// LOSS state on lock loss, deskew timeout or repeated misaligned AMs.
// Ports:
//   clk, nreset      - clock and synchronous active-low reset
//   block_lock_v_i   - per-lane 66b block lock
//   am_lock_v_i      - per-lane alignment-marker lock
//   am_v_i           - per-lane AM strobe after deskew
//   deskew_done_i    - deskew stage reports alignment
//   deskew_rst_o     - 1-cycle restart pulse for the deskew stage
//   lane_resync_o    - 1-cycle per-lane lock restart pulses
//   rx_en_o          - descrambler/decoder enable
//   align_status_o   - PCS alignment status
//   am_err_cnt_o     - saturating count of alignment losses
//   state_o          - encoded FSM state
module pcs_rx_align_ctrl
    import pcs_rx_pkg::*;
#(
    parameter int unsigned LANE_N     = LANE_N_40G,
    parameter int unsigned AM_PERIOD  = AM_PERIOD_40G,
    parameter int unsigned DESKEW_TO  = 4 * AM_PERIOD,
    parameter int unsigned AM_ERR_MAX = 3,
    parameter int unsigned CNT_W      = $clog2(DESKEW_TO + 1)
) (
    input  logic              clk,
    input  logic              nreset,
    input  logic [LANE_N-1:0] block_lock_v_i,
    input  logic [LANE_N-1:0] am_lock_v_i,
    input  logic [LANE_N-1:0] am_v_i,
    input  logic              deskew_done_i,
    output logic              deskew_rst_o,
    output logic [LANE_N-1:0] lane_resync_o,
    output logic              rx_en_o,
    output logic              align_status_o,
    output logic [7:0]        am_err_cnt_o,
    output logic [2:0]        state_o
);

    localparam int unsigned ERR_W = $clog2(AM_ERR_MAX + 1);
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(DESKEW_TO - 1);

    align_state_e      state_q, state_d;
    logic [CNT_W-1:0]  to_cnt_q, to_cnt_d;
    logic              deskew_rst_q, deskew_rst_d;
    logic [LANE_N-1:0] lane_resync_q, lane_resync_d;
    logic              align_q, align_d;
    logic [7:0]        loss_cnt_q, loss_cnt_d;

    logic              lock_ok, all_am, am_event;
    logic              err_clr, err_inc, err_hit;
    logic [ERR_W-1:0]  err_cnt;
    logic [LANE_N-1:0] lane_miss;
    logic              enter_loss;

    assign lock_ok   = (&block_lock_v_i) && (&am_lock_v_i);
    assign all_am    = &am_v_i;
    assign am_event  = |am_v_i;
    assign lane_miss = ~(block_lock_v_i & am_lock_v_i);

    // Count only while aligned; lock drop takes priority so it never counts.
    assign err_clr = (state_q != StAligned) || all_am;
    assign err_inc = (state_q == StAligned) && am_event && !all_am && lock_ok;

    pcs_rx_align_err_cnt #(
        .WIDTH  (ERR_W),
        .THRESH (AM_ERR_MAX)
    ) u_am_err_cnt (
        .clk    (clk),
        .nreset (nreset),
        .clr_i  (err_clr),
        .inc_i  (err_inc),
        .cnt_o  (err_cnt),
        .hit_o  (err_hit)
    );

    always_comb begin
        state_d  = state_q;
        to_cnt_d = to_cnt_q;
        unique case (state_q)
            StWaitBlk: begin
                if (&block_lock_v_i) state_d = StWaitAm;
            end
            StWaitAm: begin
                to_cnt_d = '0;
                if (!(&block_lock_v_i)) begin
                    state_d = StWaitBlk;
                end else if (&am_lock_v_i) begin
                    state_d = StDeskew;
                end
            end
            StDeskew: begin
                if (to_cnt_q != TO_LAST) to_cnt_d = to_cnt_q + 1'b1;
                if (!lock_ok) begin
                    state_d = StLoss;
                end else if (deskew_done_i && all_am) begin
                    state_d = StAligned;
                end else if (to_cnt_q == TO_LAST) begin
                    state_d = StLoss;
                end
            end
            StAligned: begin
                if (!lock_ok || err_hit) state_d = StLoss;
            end
            StLoss: begin
                state_d = StWaitBlk;
            end
            default: begin
                state_d = StWaitBlk;
            end
        endcase
    end

    // Outputs are registered off the transition so pulses line up with the new state.
    always_comb begin
        enter_loss    = (state_d == StLoss) && (state_q != StLoss);
        deskew_rst_d  = (state_q == StWaitAm) && (state_d == StDeskew);
        align_d       = (state_d == StAligned);
        lane_resync_d = '0;
        loss_cnt_d    = loss_cnt_q;
        if (enter_loss) begin
            // With every lane still locked (AM mismatch or timeout) resync them all.
            lane_resync_d = (lane_miss == '0) ? '1 : lane_miss;
            if (loss_cnt_q != 8'hff) loss_cnt_d = loss_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!nreset) begin
            state_q       <= StWaitBlk;
            to_cnt_q      <= '0;
            deskew_rst_q  <= 1'b0;
            lane_resync_q <= '0;
            align_q       <= 1'b0;
            loss_cnt_q    <= 8'd0;
        end else begin
            state_q       <= state_d;
            to_cnt_q      <= to_cnt_d;
            deskew_rst_q  <= deskew_rst_d;
            lane_resync_q <= lane_resync_d;
            align_q       <= align_d;
            loss_cnt_q    <= loss_cnt_d;
        end
    end

    assign deskew_rst_o   = deskew_rst_q;
    assign lane_resync_o  = lane_resync_q;
    assign rx_en_o        = align_q;
    assign align_status_o = align_q;
    assign am_err_cnt_o   = loss_cnt_q;
    assign state_o        = state_q;

endmodule

// File: tb/tb_pcs_rx_align_ctrl.sv
// Bench for pcs_rx_align_ctrl: table of {inputs, expected outputs} vectors applied one
// clock each, with expectations queued at drive time and compared 1 time unit after the edge.
module tb_pcs_rx_align_ctrl;

    localparam int unsigned LANES = 4;

    logic             clk;
    logic             nreset;
    logic [LANES-1:0] block_lock_v;
    logic [LANES-1:0] am_lock_v;
    logic [LANES-1:0] am_v;
    logic             deskew_done;
    logic             deskew_rst;
    logic [LANES-1:0] lane_resync;
    logic             rx_en;
    logic             align_status;
    logic [7:0]       am_err_cnt;
    logic [2:0]       state;

    pcs_rx_align_ctrl #(
        .LANE_N     (LANES),
        .DESKEW_TO  (100),
        .AM_ERR_MAX (3)
    ) dut (
        .clk            (clk),
        .nreset         (nreset),
        .block_lock_v_i (block_lock_v),
        .am_lock_v_i    (am_lock_v),
        .am_v_i         (am_v),
        .deskew_done_i  (deskew_done),
        .deskew_rst_o   (deskew_rst),
        .lane_resync_o  (lane_resync),
        .rx_en_o        (rx_en),
        .align_status_o (align_status),
        .am_err_cnt_o   (am_err_cnt),
        .state_o        (state)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic [3:0] blk;
        logic [3:0] aml;
        logic [3:0] amv;
        logic       done;
        logic       nrst;
        logic [2:0] st;
        logic       al;
        logic       dsk;
        logic [3:0] rsy;
        logic [7:0] cnt;
    } vec_t;

    vec_t  exp_q[$];
    vec_t  tbl[$];
    int    n_checks = 0;
    int    n_fail   = 0;
    int    step_no  = 0;
    string tag      = "init";

    function automatic vec_t mk(input logic [3:0] blk, input logic [3:0] aml,
                                input logic [3:0] amv, input logic done, input logic nrst,
                                input logic [2:0] st, input logic al, input logic dsk,
                                input logic [3:0] rsy, input logic [7:0] cnt);
        vec_t v;
        v.blk = blk; v.aml = aml; v.amv = amv; v.done = done; v.nrst = nrst;
        v.st = st; v.al = al; v.dsk = dsk; v.rsy = rsy; v.cnt = cnt;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s.%s step %0d: got %0h want %0h", tag, name, step_no, act, exp);
        end
    endtask

    task automatic step(input vec_t v);
        vec_t e;
        block_lock_v = v.blk;
        am_lock_v    = v.aml;
        am_v         = v.amv;
        deskew_done  = v.done;
        nreset       = v.nrst;
        exp_q.push_back(v);
        @(posedge clk);
        #1;
        step_no++;
        e = exp_q.pop_front();
        check("state", 32'(state), 32'(e.st));
        check("align_status", 32'(align_status), 32'(e.al));
        check("rx_en", 32'(rx_en), 32'(e.al));
        check("deskew_rst", 32'(deskew_rst), 32'(e.dsk));
        check("lane_resync", 32'(lane_resync), 32'(e.rsy));
        check("am_err_cnt", 32'(am_err_cnt), 32'(e.cnt));
    endtask

    initial begin
        logic [3:0] f;
        logic [7:0] sat;
        f = 4'hf;
        nreset = 1'b0; block_lock_v = '0; am_lock_v = '0; am_v = '0; deskew_done = 1'b0;

        // Table: bring-up corners, AM mismatch tolerance, lock loss, resets.
        //            blk      aml      amv      dn nr  st al ds rsy      cnt
        tbl.push_back(mk(4'h0, 4'h0, 4'h0, 0, 0, 0, 0, 0, 4'h0, 0));
        tbl.push_back(mk(4'h1, 4'h0, 4'h0, 0, 1, 0, 0, 0, 4'h0, 0));
        tbl.push_back(mk(4'h7, 4'h0, 4'h0, 0, 1, 0, 0, 0, 4'h0, 0));
        tbl.push_back(mk(f,    4'h0, 4'h0, 0, 1, 1, 0, 0, 4'h0, 0));
        tbl.push_back(mk(f,    4'h3, 4'h0, 0, 1, 1, 0, 0, 4'h0, 0));
        tbl.push_back(mk(4'h7, 4'h3, 4'h0, 0, 1, 0, 0, 0, 4'h0, 0));
        tbl.push_back(mk(f,    4'h0, 4'h0, 0, 1, 1, 0, 0, 4'h0, 0));
        tbl.push_back(mk(f,    f,    4'h0, 0, 1, 2, 0, 1, 4'h0, 0));
        tbl.push_back(mk(f,    f,    4'h0, 0, 1, 2, 0, 0, 4'h0, 0));
        tbl.push_back(mk(f,    f,    4'h7, 1, 1, 2, 0, 0, 4'h0, 0));
        tbl.push_back(mk(f,    f,    f,    0, 1, 2, 0, 0, 4'h0, 0));
        tbl.push_back(mk(f,    f,    f,    1, 1, 3, 1, 0, 4'h0, 0));
        tbl.push_back(mk(f,    f,    4'h0, 1, 1, 3, 1, 0, 4'h0, 0));
        tbl.push_back(mk(f,    f,    4'hb, 1, 1, 3, 1, 0, 4'h0, 0));
        tbl.push_back(mk(f,    f,    4'h0, 1, 1, 3, 1, 0, 4'h0, 0));
        tbl.push_back(mk(f,    f,    4'hb, 1, 1, 3, 1, 0, 4'h0, 0));
        tbl.push_back(mk(f,    f,    f,    1, 1, 3, 1, 0, 4'h0, 0));
        tbl.push_back(mk(f,    f,    4'h7, 1, 1, 3, 1, 0, 4'h0, 0));
        tbl.push_back(mk(f,    f,    4'h7, 1, 1, 3, 1, 0, 4'h0, 0));
        tbl.push_back(mk(f,    f,    4'h7, 1, 1, 4, 0, 0, f,    1));
        tbl.push_back(mk(f,    f,    4'h0, 1, 1, 0, 0, 0, 4'h0, 1));
        tbl.push_back(mk(f,    f,    4'h0, 1, 1, 1, 0, 0, 4'h0, 1));
        tbl.push_back(mk(f,    f,    4'h0, 1, 1, 2, 0, 1, 4'h0, 1));
        tbl.push_back(mk(f,    f,    f,    1, 1, 3, 1, 0, 4'h0, 1));
        tbl.push_back(mk(4'hb, f,    f,    1, 1, 4, 0, 0, 4'h4, 2));
        tbl.push_back(mk(4'hb, f,    4'h0, 0, 1, 0, 0, 0, 4'h0, 2));
        tbl.push_back(mk(f,    f,    4'h0, 0, 1, 1, 0, 0, 4'h0, 2));
        tbl.push_back(mk(f,    f,    4'h0, 0, 1, 2, 0, 1, 4'h0, 2));
        tbl.push_back(mk(f,    f,    4'h0, 0, 0, 0, 0, 0, 4'h0, 0));
        tbl.push_back(mk(f,    f,    4'h0, 0, 1, 1, 0, 0, 4'h0, 0));
        tbl.push_back(mk(f,    f,    4'h0, 0, 1, 2, 0, 1, 4'h0, 0));
        tbl.push_back(mk(f,    4'hd, 4'h0, 0, 1, 4, 0, 0, 4'h2, 1));
        tbl.push_back(mk(f,    4'hd, 4'h0, 0, 1, 0, 0, 0, 4'h0, 1));
        tbl.push_back(mk(f,    f,    4'h0, 0, 1, 1, 0, 0, 4'h0, 1));
        tbl.push_back(mk(f,    f,    4'h0, 0, 1, 2, 0, 1, 4'h0, 1));
        tbl.push_back(mk(f,    f,    f,    1, 1, 3, 1, 0, 4'h0, 1));
        tbl.push_back(mk(f,    f,    f,    1, 0, 0, 0, 0, 4'h0, 0));
        tbl.push_back(mk(4'h0, 4'h0, 4'h0, 0, 1, 0, 0, 0, 4'h0, 0));

        // Nominal bring-up on the cycle schedule: inputs of cycle c show up at cycle c+1.
        tag = "bringup";
        step(mk(4'h0, 4'h0, 4'h0, 0, 0, 0, 0, 0, 4'h0, 0));
        for (int c = 0; c < 80; c++) begin
            vec_t v;
            int   n;
            n = c + 1;
            v = mk({c >= 20, c >= 15, c >= 12, c >= 10}, (c >= 40) ? f : 4'h0,
                   (c == 70) ? f : 4'h0, c >= 60, 1'b1,
                   (n <= 20) ? 3'd0 : (n <= 40) ? 3'd1 : (n <= 70) ? 3'd2 : 3'd3,
                   n >= 71, n == 41, 4'h0, 8'd0);
            step(v);
        end

        tag = "table";
        for (int i = 0; i < tbl.size(); i++) step(tbl[i]);

        // Deskew timeout: DESKEW lasts exactly 100 cycles, then LOSS resyncs all lanes.
        tag = "timeout";
        step(mk(f, 4'h0, 4'h0, 0, 1, 1, 0, 0, 4'h0, 0));
        step(mk(f, f,    4'h0, 0, 1, 2, 0, 1, 4'h0, 0));
        for (int i = 0; i < 99; i++) step(mk(f, f, 4'h0, 0, 1, 2, 0, 0, 4'h0, 0));
        step(mk(f, f, 4'h0, 0, 1, 4, 0, 0, f,    1));
        step(mk(f, f, 4'h0, 0, 1, 0, 0, 0, 4'h0, 1));

        // Loss counter saturation over 300 lock-drop losses.
        tag = "saturate";
        step(mk(4'h0, 4'h0, 4'h0, 0, 0, 0, 0, 0, 4'h0, 0));
        sat = 8'd0;
        for (int i = 0; i < 300; i++) begin
            step(mk(f, f,    4'h0, 0, 1, 1, 0, 0, 4'h0, sat));
            step(mk(f, f,    4'h0, 0, 1, 2, 0, 1, 4'h0, sat));
            if (sat != 8'd255) sat = sat + 8'd1;
            step(mk(f, 4'he, 4'h0, 0, 1, 4, 0, 0, 4'h1, sat));
            step(mk(f, 4'he, 4'h0, 0, 1, 0, 0, 0, 4'h0, sat));
        end
        check("final_sat", 32'(am_err_cnt), 32'd255);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
